rst_seq_release: RTL and testbench



---
 rtl/rst_seq_release.sv | 134 +++++++++++++
 tb/tb_rst_seq_release.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/rst_seq_release.sv
// -----------------------------------------------------------------------------
// rst_seq_release
//
// Reset-release sequencer. An asynchronous clear forces every staged reset
// output high at once. When the clear goes away, its removal is first passed
// through a short synchronizer clocked by C, and then the reset domains are
// released one at a time, HOLD_CYCLES active edges apart, lowest bit first.
// A synchronous re-sequence request restarts the staged release without
// going back through the synchronizer.
//
// Parameters:
//   IS_C_INVERTED   - 1: all state updates on the falling edge of C
//   IS_CLR_INVERTED - CLR is XORed with this bit before use
//   SYNC_STAGES     - depth of the release synchronizer (2..8)
//   NUM_OUTS        - number of staged reset outputs (1..16)
//   HOLD_CYCLES     - active edges between successive releases (1..65535)
//
// Ports:
//   C        in   clock
//   CLR      in   asynchronous clear, active-high after IS_CLR_INVERTED
//   REQ      in   synchronous re-sequence request
//   RST_OUT  out  staged resets, active-high, bit 0 releases first
//   DONE     out  high once every RST_OUT bit has been released
// -----------------------------------------------------------------------------
module rst_seq_release #(
    parameter logic IS_C_INVERTED   = 1'b0,
    parameter logic IS_CLR_INVERTED = 1'b0,
    parameter int   SYNC_STAGES     = 3,
    parameter int   NUM_OUTS        = 4,
    parameter int   HOLD_CYCLES     = 16
) (
    input  logic                C,
    input  logic                CLR,
    input  logic                REQ,
    output logic [NUM_OUTS-1:0] RST_OUT,
    output logic                DONE
);

    // Counter widths never drop below one bit, so the single-output and
    // single-cycle-hold configurations still have a real register to compare.
    localparam int CNT_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam int IDX_W = (NUM_OUTS > 1) ? $clog2(NUM_OUTS) : 1;

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(NUM_OUTS - 1);

    typedef enum logic [1:0] {
        ST_SYNC = 2'd0,
        ST_HOLD = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    logic                   clkInt;
    logic                   clrInt;
    logic [SYNC_STAGES-1:0] syncChain_q;
    state_t                 state_q;
    logic [CNT_W-1:0]       cnt_q;
    logic [IDX_W-1:0]       idx_q;
    logic [NUM_OUTS-1:0]    rstOut_q;
    logic                   done_q;
    logic [NUM_OUTS-1:0]    releaseMask_d;

    // Polarity selection is done once here so the rest of the design only
    // ever sees a rising active edge and an active-high clear.
    assign clkInt = C ^ IS_C_INVERTED;
    assign clrInt = CLR ^ IS_CLR_INVERTED;

    // One-hot mask picking the output that releases on the current hold
    // expiry. Built as a shift so no bit-select with a variable index is
    // needed on the output register.
    always_comb begin
        releaseMask_d = NUM_OUTS'(1) << idx_q;
    end

    // Sequencer. The synchronizer shifts zeros in on every edge once the
    // clear is gone; a re-sequence request does not re-arm it, so after the
    // first release the chain simply stays at zero. REQ has priority over
    // anything the FSM would otherwise do on the same edge, including a
    // release that was due on that edge.
    always_ff @(posedge clkInt or posedge clrInt) begin
        if (clrInt) begin
            syncChain_q <= '1;
            state_q     <= ST_SYNC;
            cnt_q       <= '0;
            idx_q       <= '0;
            rstOut_q    <= '1;
            done_q      <= 1'b0;
        end else begin
            syncChain_q <= {syncChain_q[SYNC_STAGES-2:0], 1'b0};
            if (REQ) begin
                state_q  <= ST_HOLD;
                cnt_q    <= '0;
                idx_q    <= '0;
                rstOut_q <= '1;
                done_q   <= 1'b0;
            end else begin
                case (state_q)
                    ST_SYNC: begin
                        if (!syncChain_q[SYNC_STAGES-1]) begin
                            state_q <= ST_HOLD;
                            cnt_q   <= '0;
                            idx_q   <= '0;
                        end
                    end
                    ST_HOLD: begin
                        if (cnt_q == CNT_MAX) begin
                            rstOut_q <= rstOut_q & ~releaseMask_d;
                            cnt_q    <= '0;
                            if (idx_q == IDX_MAX) begin
                                state_q <= ST_DONE;
                                done_q  <= 1'b1;
                            end else begin
                                idx_q <= idx_q + 1'b1;
                            end
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                    ST_DONE: begin
                        rstOut_q <= '0;
                        done_q   <= 1'b1;
                    end
                    default: begin
                        state_q <= ST_SYNC;
                    end
                endcase
            end
        end
    end

    assign RST_OUT = rstOut_q;
    assign DONE    = done_q;

endmodule

// File: tb/tb_rst_seq_release.sv
// -----------------------------------------------------------------------------
// tb_rst_seq_release
//
// Three sequencer instances share one clock:
//   u0 - default parameters
//   u1 - HOLD_CYCLES=1, NUM_OUTS=3, SYNC_STAGES=2
//   u2 - inverted clock and inverted clear
// u0/u1 share one set of inputs and are exercised first while u2 is held in
// clear; then u2 is exercised on falling edges while u0/u1 are held in clear.
//
// The reference model works purely from the release-time rules: it counts
// active edges since the clear went away and keeps an anchor edge (S+1 after
// a clear release, or the edge of the latest REQ). Bit i is released once
// the edge count reaches anchor + (i+1)*HOLD_CYCLES.
// -----------------------------------------------------------------------------
module tb_rst_seq_release;

    logic       C = 1'b0;
    logic       clrA;
    logic       reqA;
    logic       clrB;
    logic       reqB;
    logic [3:0] rst0;
    logic       done0;
    logic [2:0] rst1;
    logic       done1;
    logic [3:0] rst2;
    logic       done2;

    int numChecks = 0;
    int numFails  = 0;

    // Per-instance parameters as seen by the model
    int pS[3] = '{3, 2, 3};
    int pN[3] = '{4, 3, 4};
    int pH[3] = '{16, 1, 16};

    // Model state: edges since clear release, and the current anchor edge
    int mCnt[3];
    int mAnchor[3];

    always #5 C = ~C;

    rst_seq_release u0 (
        .C(C), .CLR(clrA), .REQ(reqA), .RST_OUT(rst0), .DONE(done0)
    );

    rst_seq_release #(
        .SYNC_STAGES(2), .NUM_OUTS(3), .HOLD_CYCLES(1)
    ) u1 (
        .C(C), .CLR(clrA), .REQ(reqA), .RST_OUT(rst1), .DONE(done1)
    );

    rst_seq_release #(
        .IS_C_INVERTED(1'b1), .IS_CLR_INVERTED(1'b1)
    ) u2 (
        .C(C), .CLR(clrB), .REQ(reqB), .RST_OUT(rst2), .DONE(done2)
    );

    // Single comparison point: counts and reports
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        numChecks++;
        if (observed !== expected) begin
            numFails++;
            $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic modelClear(input int k);
        mCnt[k]    = 0;
        mAnchor[k] = pS[k] + 1;
    endtask

    task automatic modelEdge(input int k, input bit clrActive, input bit req);
        if (clrActive) begin
            modelClear(k);
        end else begin
            mCnt[k]++;
            if (req) mAnchor[k] = mCnt[k];
        end
    endtask

    function automatic logic [15:0] expRst(input int k);
        logic [15:0] e;
        e = '0;
        for (int i = 0; i < 16; i++) begin
            if (i < pN[k]) e[i] = !(mCnt[k] >= mAnchor[k] + (i + 1) * pH[k]);
        end
        return e;
    endfunction

    function automatic logic expDone(input int k);
        return (expRst(k) == 16'h0);
    endfunction

    task automatic checkDut(input int k, input string tag);
        logic [15:0] r;
        logic        d;
        case (k)
            0:       begin r = 16'(rst0); d = done0; end
            1:       begin r = 16'(rst1); d = done1; end
            default: begin r = 16'(rst2); d = done2; end
        endcase
        checkOutput($sformatf("%s_u%0d_rst", tag, k), 32'(r), 32'(expRst(k)));
        checkOutput($sformatf("%s_u%0d_done", tag, k), 32'(d), 32'(expDone(k)));
    endtask

    // One rising edge for u0/u1, then check both 1 ns later
    task automatic tickA(input string tag);
        @(posedge C);
        modelEdge(0, clrA, reqA);
        modelEdge(1, clrA, reqA);
        #1;
        checkDut(0, tag);
        checkDut(1, tag);
    endtask

    // One falling edge for u2; also confirm nothing moves on the rising edge
    task automatic tickB(input string tag);
        @(negedge C);
        modelEdge(2, !clrB, reqB);
        #1;
        checkDut(2, tag);
        @(posedge C);
        #1;
        checkDut(2, {tag, "_pos"});
    endtask

    task automatic applyStimulus(input logic clrVal, input logic reqVal);
        clrA = clrVal;
        reqA = reqVal;
    endtask

    // Clear pulse placed between edges; outputs must react with no clock
    task automatic asyncPulseA(input string tag);
        #2;
        clrA = 1'b1;
        #1;
        modelClear(0);
        modelClear(1);
        checkOutput({tag, "_rst0_imm"}, 32'(rst0), 32'h0000000F);
        checkOutput({tag, "_done0_imm"}, 32'(done0), 32'h0);
        checkDut(0, tag);
        checkDut(1, tag);
        #1;
        clrA = 1'b0;
    endtask

    // Full release after the clear goes low, with fixed timing landmarks
    task automatic releaseSequence(input string tag);
        for (int n = 1; n <= 70; n++) begin
            tickA(tag);
            if (n == 19) checkOutput({tag, "_e19"}, 32'(rst0), 32'hF);
            if (n == 20) checkOutput({tag, "_e20"}, 32'(rst0), 32'hE);
            if (n == 36) checkOutput({tag, "_e36"}, 32'(rst0), 32'hC);
            if (n == 52) checkOutput({tag, "_e52"}, 32'(rst0), 32'h8);
            if (n == 67) checkOutput({tag, "_e67_done"}, 32'(done0), 32'h0);
            if (n == 68) begin
                checkOutput({tag, "_e68"}, 32'(rst0), 32'h0);
                checkOutput({tag, "_e68_done"}, 32'(done0), 32'h1);
            end
            if (n == 3) checkOutput({tag, "_u1_e3"}, 32'(rst1), 32'h7);
            if (n == 4) checkOutput({tag, "_u1_e4"}, 32'(rst1), 32'h6);
            if (n == 5) checkOutput({tag, "_u1_e5"}, 32'(rst1), 32'h4);
            if (n == 6) begin
                checkOutput({tag, "_u1_e6"}, 32'(rst1), 32'h0);
                checkOutput({tag, "_u1_e6_done"}, 32'(done1), 32'h1);
            end
        end
    endtask

    // Release after the last REQ edge, with fixed timing landmarks
    task automatic afterRequest(input string tag);
        for (int k = 1; k <= 70; k++) begin
            tickA(tag);
            if (k == 15) checkOutput({tag, "_r15"}, 32'(rst0), 32'hF);
            if (k == 16) checkOutput({tag, "_r16"}, 32'(rst0), 32'hE);
            if (k == 63) checkOutput({tag, "_r63_done"}, 32'(done0), 32'h0);
            if (k == 64) begin
                checkOutput({tag, "_r64"}, 32'(rst0), 32'h0);
                checkOutput({tag, "_r64_done"}, 32'(done0), 32'h1);
            end
        end
    endtask

    initial begin
        clrA = 1'b0;
        reqA = 1'b0;
        clrB = 1'b1;
        reqB = 1'b0;
        for (int k = 0; k < 3; k++) modelClear(k);

        // Assert clear on every instance before the first edge
        #1;
        clrA = 1'b1;
        clrB = 1'b0;
        #1;
        checkDut(0, "reset");
        checkDut(1, "reset");
        checkDut(2, "reset");
        checkOutput("reset_rst0", 32'(rst0), 32'hF);
        #1;
        applyStimulus(1'b0, 1'b0);

        releaseSequence("pwrup");

        // Single REQ edge while in DONE
        applyStimulus(1'b0, 1'b1);
        tickA("reqR");
        checkOutput("reqR_rst0", 32'(rst0), 32'hF);
        checkOutput("reqR_done0", 32'(done0), 32'h0);
        applyStimulus(1'b0, 1'b0);
        afterRequest("reqPulse");

        // REQ held for 30 edges: outputs must stay all high
        applyStimulus(1'b0, 1'b1);
        for (int k = 0; k < 30; k++) begin
            tickA("reqHeld");
            checkOutput("reqHeld_rst0", 32'(rst0), 32'hF);
        end
        applyStimulus(1'b0, 1'b0);
        afterRequest("reqHeldRel");

        // Clear arriving mid-sequence between edges 40 and 41
        applyStimulus(1'b1, 1'b0);
        tickA("clrHold");
        applyStimulus(1'b0, 1'b0);
        for (int n = 1; n <= 40; n++) tickA("preAsync");
        asyncPulseA("async40");
        clrA = 1'b1;
        tickA("clrHeld");
        tickA("clrHeld");
        #1;
        clrA = 1'b0;
        releaseSequence("postAsync");

        // Randomized REQ and clear pulses against the model
        for (int i = 0; i < 400; i++) begin
            reqA = ($urandom_range(0, 15) == 0);
            tickA("randA");
            if ($urandom_range(0, 59) == 0) asyncPulseA("randClr");
        end

        // Second phase: park u0/u1 in clear, run the inverted instance
        applyStimulus(1'b1, 1'b0);
        clrB = 1'b1;
        for (int n = 1; n <= 70; n++) begin
            tickB("inv");
            if (n == 19) checkOutput("inv_e19", 32'(rst2), 32'hF);
            if (n == 20) checkOutput("inv_e20", 32'(rst2), 32'hE);
            if (n == 36) checkOutput("inv_e36", 32'(rst2), 32'hC);
            if (n == 52) checkOutput("inv_e52", 32'(rst2), 32'h8);
            if (n == 68) begin
                checkOutput("inv_e68", 32'(rst2), 32'h0);
                checkOutput("inv_e68_done", 32'(done2), 32'h1);
            end
        end
        for (int i = 0; i < 150; i++) begin
            reqB = ($urandom_range(0, 19) == 0);
            tickB("randB");
        end
        reqB = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", numChecks, numFails);
        $finish;
    end

endmodule
